// File: rtl/rx_module.sv
// UART receiver: 16x oversampled, 5..8 data bits, optional even parity, 1..4 stop bits.
// Line is double-flopped; the FSM and datapath only move on baud_en_i ticks.
module rx_module #(
   parameter int MAX_UART_DATA_W    = 8,
   parameter int STOP_CONF_WIDTH    = 2,
   parameter int DATA_CONF_WIDTH    = 2,
   parameter int SAMPLE_COUNT_WIDTH = 4,
   parameter int TOTAL_CONF_WIDTH   = 5
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        baud_en_i,
   input  logic                        rx_en_i,
   input  logic [TOTAL_CONF_WIDTH-1:0] rx_conf_i,
   input  logic                        uart_rx_i,
   output logic [MAX_UART_DATA_W-1:0]  rx_data_o,
   output logic                        rx_done_o,
   output logic                        rx_busy_o,
   output logic                        parity_err_o,
   output logic                        frame_err_o
);

   localparam int BIT_W = (MAX_UART_DATA_W > 1) ? $clog2(MAX_UART_DATA_W) : 1;
   localparam logic [SAMPLE_COUNT_WIDTH-1:0] C_MID =
      SAMPLE_COUNT_WIDTH'((1 << (SAMPLE_COUNT_WIDTH - 1)) - 1);
   localparam logic [SAMPLE_COUNT_WIDTH-1:0] C_END = {SAMPLE_COUNT_WIDTH{1'b1}};

   typedef enum logic [2:0] {
      ST_RESET,
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_DONE
   } state_t;

   state_t                          r_state;
   state_t                          w_state_next;
   logic [1:0]                      r_sync;
   logic                            w_rx;
   logic [SAMPLE_COUNT_WIDTH-1:0]   r_cnt;
   logic [BIT_W-1:0]                r_bit_idx;
   logic [BIT_W-1:0]                r_last_idx;
   logic [STOP_CONF_WIDTH-1:0]      r_stop_idx;
   logic [STOP_CONF_WIDTH-1:0]      r_stop_last;
   logic                            r_par_en;
   logic                            r_par_acc;
   logic                            r_par_err;
   logic                            r_frame_acc;
   logic [MAX_UART_DATA_W-1:0]      r_shift;
   logic                            w_mid;
   logic                            w_end;
   logic                            w_done_entry;

   // Synchroniser idles high so reset never looks like a start bit.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_sync <= 2'b11;
      else       r_sync <= {r_sync[0], uart_rx_i};
   end

   assign w_rx         = r_sync[1];
   assign w_mid        = (r_cnt == C_MID);
   assign w_end        = (r_cnt == C_END);
   assign w_done_entry = (r_state == ST_STOP) && (w_state_next == ST_DONE);
   assign rx_busy_o    = (r_state == ST_START) || (r_state == ST_DATA) ||
                         (r_state == ST_PARITY) || (r_state == ST_STOP);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= ST_RESET;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if (baud_en_i) begin
         case (r_state)
            ST_RESET:  if (rx_en_i) w_state_next = ST_IDLE;
            ST_IDLE:   if (!w_rx) w_state_next = ST_START;
            ST_START:  if (w_mid) w_state_next = w_rx ? ST_IDLE : ST_DATA;
            ST_DATA:   if (w_end && (r_bit_idx == r_last_idx))
                          w_state_next = r_par_en ? ST_PARITY : ST_STOP;
            ST_PARITY: if (w_end) w_state_next = ST_STOP;
            // Done is entered at the centre of the last stop bit, not its end.
            ST_STOP:   if (w_end && (r_stop_idx == r_stop_last)) w_state_next = ST_DONE;
            ST_DONE:   w_state_next = rx_en_i ? ST_IDLE : ST_RESET;
            default:   w_state_next = ST_RESET;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cnt        <= '0;
         r_bit_idx    <= '0;
         r_last_idx   <= '0;
         r_stop_idx   <= '0;
         r_stop_last  <= '0;
         r_par_en     <= 1'b0;
         r_par_acc    <= 1'b0;
         r_par_err    <= 1'b0;
         r_frame_acc  <= 1'b0;
         r_shift      <= '0;
         rx_data_o    <= '0;
         rx_done_o    <= 1'b0;
         parity_err_o <= 1'b0;
         frame_err_o  <= 1'b0;
      end else begin
         rx_done_o <= w_done_entry;
         if (baud_en_i) begin
            case (r_state)
               ST_IDLE: if (!w_rx) begin
                  r_cnt       <= '0;
                  r_bit_idx   <= '0;
                  r_stop_idx  <= '0;
                  r_shift     <= '0;
                  r_par_acc   <= 1'b0;
                  r_par_err   <= 1'b0;
                  r_frame_acc <= 1'b0;
                  r_last_idx  <= BIT_W'(4) +
                                 BIT_W'(rx_conf_i[TOTAL_CONF_WIDTH-1 -: DATA_CONF_WIDTH]);
                  r_stop_last <= rx_conf_i[STOP_CONF_WIDTH:1];
                  r_par_en    <= rx_conf_i[0];
               end
               ST_START: r_cnt <= w_mid ? '0 : r_cnt + 1'b1;
               // Counter wraps 15 -> 0 naturally, lining up the next bit.
               ST_DATA: begin
                  r_cnt <= r_cnt + 1'b1;
                  if (w_end) begin
                     r_shift[r_bit_idx] <= w_rx;
                     r_par_acc          <= r_par_acc ^ w_rx;
                     r_bit_idx          <= r_bit_idx + 1'b1;
                  end
               end
               ST_PARITY: begin
                  r_cnt <= r_cnt + 1'b1;
                  if (w_end) r_par_err <= w_rx ^ r_par_acc;
               end
               ST_STOP: begin
                  r_cnt <= r_cnt + 1'b1;
                  if (w_end) begin
                     if (!w_rx) r_frame_acc <= 1'b1;
                     r_stop_idx <= r_stop_idx + 1'b1;
                  end
               end
               default: ;
            endcase
         end
         if (w_done_entry) begin
            rx_data_o    <= r_shift;
            parity_err_o <= r_par_en & r_par_err;
            frame_err_o  <= r_frame_acc | ~w_rx;
         end
      end
   end

endmodule

// File: doc/rx_module.md
RX_MODULE -- requirements
Module: rx_module

Interface
REQ-001 SHALL have parameter MAX_UART_DATA_W, default 8: maximum data width and width of rx_data_o.
REQ-002 SHALL have parameter STOP_CONF_WIDTH, default 2: stop-bit config field width.
REQ-003 SHALL have parameter DATA_CONF_WIDTH, default 2: data-length config field width.
REQ-004 SHALL have parameter SAMPLE_COUNT_WIDTH, default 4: oversample counter width (16 ticks/bit).
REQ-005 SHALL have parameter TOTAL_CONF_WIDTH, default 5: rx_conf_i width.
REQ-006 SHALL have port clk_i, input, 1: clock.
REQ-007 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-008 SHALL have port baud_en_i, input, 1: oversample tick, 16 per bit period, one clk_i wide.
REQ-009 SHALL have port rx_en_i, input, 1: receiver enable.
REQ-010 SHALL have port rx_conf_i, input, TOTAL_CONF_WIDTH: {data[1:0], stop[1:0], parity_en}.
REQ-011 SHALL have port uart_rx_i, input, 1: asynchronous serial line, idle high.
REQ-012 SHALL have port rx_data_o, output, MAX_UART_DATA_W: received word, LSB-aligned, unused MSBs zero.
REQ-013 SHALL have port rx_done_o, output, 1: frame-complete pulse.
REQ-014 SHALL have port rx_busy_o, output, 1: frame in progress.
REQ-015 SHALL have port parity_err_o, output, 1: parity mismatch on last frame.
REQ-016 SHALL have port frame_err_o, output, 1: stop bit sampled low on last frame.

Function
REQ-017 SHALL synchronise uart_rx_i through two clk_i flops; all logic uses the synchronised value only.
REQ-018 SHALL implement FSM Reset, Idle, RecvStart, RecvData, RecvParity, RecvStop, Done; state advances only on baud_en_i.
REQ-019 Reset->Idle when rx_en_i=1; Idle->RecvStart on a baud_en_i tick with synchronised line low.
REQ-020 On Idle->RecvStart SHALL clear sample counter, latch rx_conf_i: data bits = 5 + conf[4:3] (5..8), stop bits = conf[2:1] + 1 (1..4), parity_en = conf[0].
REQ-021 RecvStart SHALL sample the line at sample count 7; high -> Idle (false start, no outputs change); low -> clear counter, enter RecvData.
REQ-022 RecvData/RecvParity/RecvStop SHALL sample the line when sample count = 15 (bit centre), then wrap counter to 0.
REQ-023 Data bits SHALL be received LSB first into bit index 0..N-1; after bit N-1 -> RecvParity if parity_en else RecvStop.
REQ-024 Parity SHALL be even: parity_err set when received parity bit != XOR of received data bits; RecvParity -> RecvStop after one bit.
REQ-025 Each stop bit sampled low SHALL set frame error; FSM SHALL enter Done at the centre sample of the final stop bit (no wait for bit end).
REQ-026 Done SHALL last one baud_en_i tick, then -> Idle if rx_en_i else Reset.
REQ-027 On Done entry SHALL update rx_data_o, parity_err_o, frame_err_o together and pulse rx_done_o high exactly one clk_i cycle; outputs hold until next Done.
REQ-028 rx_busy_o SHALL be 1 from RecvStart entry until Done entry; 0 on false start return to Idle.
REQ-029 rx_en_i deassertion mid-frame SHALL not abort the frame; it is honoured in Done.
REQ-030 Config changes on rx_conf_i during a frame SHALL have no effect until next start.
REQ-031 parity_err_o SHALL be 0 for frames with parity_en=0.

Reset
REQ-032 rst_i SHALL force state Reset, counters 0, synchroniser flops 1, rx_data_o 0, rx_done_o 0, rx_busy_o 0, parity_err_o 0, frame_err_o 0, asynchronously.
REQ-033 rst_i mid-frame SHALL discard the partial frame; no rx_done_o pulse follows release.

Verification
REQ-034 8N1, rx_en_i=1, send 0xA5 -> one rx_done_o pulse, rx_data_o=0xA5, both errors 0.
REQ-035 conf data=0 (5 bits), parity_en=1, send 0x13 with parity bit 1 -> rx_data_o=0x13, parity_err_o=0; same with parity bit 0 -> parity_err_o=1.
REQ-036 Line low for 4 ticks then high -> return to Idle, no rx_done_o, rx_busy_o pulses then 0.
REQ-037 2 stop bits, second stop low, data 0x3C -> rx_data_o=0x3C, frame_err_o=1.
REQ-038 Back-to-back frames 0x55,0xAA with 1 stop bit, no idle gap -> two rx_done_o pulses, correct data each.
REQ-039 Assert rst_i during data bit 3 -> all outputs 0 immediately; next clean frame 0x0F received correctly.
